pc_unit: RTL

Parametrised program-counter unit for the RISC core, replacing the fixed 3-bit load/increment counter.
- Supports hold, increment, absolute jump, PC-relative branch, and call/return.
- Call/return use an internal return-address stack (RAS).
- Sits between the control unit (drives op/enab) and instruction memory (consumes pc).

---
 rtl/pc_pkg.sv | 14 +
 rtl/ras_stack.sv | 55 +++++
 rtl/pc_unit.sv | 93 +++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared op codes for the program-counter unit and its control-unit driver.
package pc_pkg;

  typedef logic [2:0] pc_op_t;

  localparam pc_op_t OP_HOLD   = 3'd0;
  localparam pc_op_t OP_INC    = 3'd1;
  localparam pc_op_t OP_JUMP   = 3'd2;
  localparam pc_op_t OP_BRANCH = 3'd3;
  localparam pc_op_t OP_CALL   = 3'd4;
  localparam pc_op_t OP_RET    = 3'd5;
  // Codes 6 and 7 are reserved: they act as OP_HOLD and never raise stk_err.

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: strict LIFO, top = entry[depth-1].
// Push when full and pop when empty are silently ignored.
module ras_stack #(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 4,
  localparam int DW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] entries_q [STACK_DEPTH];
  logic [DW-1:0]    depth_q, depth_d;

  assign full  = (depth_q == DW'(STACK_DEPTH));
  assign empty = (depth_q == '0);
  assign depth = depth_q;

  always_comb begin
    depth_d = depth_q;
    if (push && !full)
      depth_d = depth_q + DW'(1);
    else if (pop && !empty)
      depth_d = depth_q - DW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) depth_q <= '0;
    else     depth_q <= depth_d;
  end

  // Entries carry no reset; depth alone defines which ones are valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (!rst && push && !full && depth_q == DW'(i))
        entries_q[i] <= din;
    end
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (depth_q == DW'(i + 1))
        top = entries_q[i];
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with hold/inc/jump/branch and call/return through a RAS.
// Handshake: none; enab=1 qualifies op for exactly one rising edge, effect visible next cycle.
module pc_unit
  import pc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 4,
  parameter int STEP        = 1,
  parameter int RESET_VEC   = 0,
  localparam int DW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enab,
  input  pc_op_t           op,
  input  logic [WIDTH-1:0] tgt,
  input  logic [WIDTH-1:0] ofs,
  output logic [WIDTH-1:0] pc,
  output logic [DW-1:0]    depth,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             stk_err
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] pc_inc, pc_br, ras_top;
  logic             push, pop, ras_full, ras_empty;

  assign pc_inc = pc_q + WIDTH'(STEP);
  // Two's-complement add gives the signed-offset branch with natural wrap.
  assign pc_br  = pc_q + ofs;

  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    push  = 1'b0;
    pop   = 1'b0;
    if (enab) begin
      case (op)
        OP_INC:    pc_d = pc_inc;
        OP_JUMP:   pc_d = tgt;
        OP_BRANCH: pc_d = pc_br;
        OP_CALL: begin
          pc_d = tgt;
          if (ras_full) err_d = 1'b1;
          else          push  = 1'b1;
        end
        OP_RET: begin
          if (ras_empty) begin
            pc_d  = pc_inc;
            err_d = 1'b1;
          end else begin
            pc_d = ras_top;
            pop  = 1'b1;
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= WIDTH'(RESET_VEC);
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  ras_stack #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (ras_top),
    .depth (depth),
    .full  (ras_full),
    .empty (ras_empty)
  );

  assign pc        = pc_q;
  assign stk_err   = err_q;
  assign stk_full  = (depth == DW'(STACK_DEPTH));
  assign stk_empty = (depth == '0);

endmodule
